mdu_iterative: RTL and testbench

//  Parametrised iterative multiply/divide unit holding the HI/LO architectural registers for the forwarding pipeline.

---
 rtl/mdu_iterative_if.sv | 25 ++
 rtl/mdu_iterative.sv | 212 +++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the EX stage and the iterative MDU.
// master drives the op request; slave (the MDU) returns status and HI/LO.
interface mdu_iterative_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 8-11).
module mdu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mdu_iterative_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd8;
  localparam logic [3:0] OpMaddu = 4'd9;
  localparam logic [3:0] OpMsub  = 4'd10;
  localparam logic [3:0] OpMsubu = 4'd11;
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic [CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]       opnd_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       a_q;
  logic                   is_div_q;
  logic                   div0_q;
  logic                   neg_q;
  logic                   rneg_q;
`ifdef MDU_MADD_EN
  logic                   accum_q;
  logic                   accum_sub_q;
  logic                   op_accum;
  logic                   op_accum_sub;
`endif

  // Op decode for the request currently on the bus.
  logic op_calc;
  logic op_signed;
  logic op_div;

  always_comb begin
    op_calc   = 1'b0;
    op_signed = 1'b0;
    op_div    = 1'b0;
`ifdef MDU_MADD_EN
    op_accum     = 1'b0;
    op_accum_sub = 1'b0;
`endif
    case (bus.op)
      OpMult:  begin op_calc = 1'b1; op_signed = 1'b1; end
      OpMultu: op_calc = 1'b1;
      OpDiv:   begin op_calc = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      OpDivu:  begin op_calc = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
      OpMadd:  begin op_calc = 1'b1; op_signed = 1'b1; op_accum = 1'b1; end
      OpMaddu: begin op_calc = 1'b1; op_accum = 1'b1; end
      OpMsub:  begin
        op_calc = 1'b1; op_signed = 1'b1; op_accum = 1'b1; op_accum_sub = 1'b1;
      end
      OpMsubu: begin op_calc = 1'b1; op_accum = 1'b1; op_accum_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Operand magnitudes; unsigned ops pass through unchanged.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = op_signed & bus.a[WIDTH-1];
    b_neg = op_signed & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One iteration step. Multiply: shift-add with multiplier in the low half.
  // Divide: restoring division, remainder in the high half, quotient shifts into the low half.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_div_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    acc_mul_d = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = rem_sh - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      acc_div_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_div_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and final HI/LO value written on the FIX edge.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] hilo_fix_d;

  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      hilo_fix_d = div0_q ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
    end else begin
      hilo_fix_d = prod;
`ifdef MDU_MADD_EN
      if (accum_q) begin
        hilo_fix_d = accum_sub_q ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`ifdef MDU_MADD_EN
      accum_q     <= 1'b0;
      accum_sub_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              if (op_calc) begin
                state_q  <= StCalc;
                busy_q   <= 1'b1;
                cnt_q    <= CntW'(WIDTH - 1);
                opnd_q   <= op_div ? b_mag : a_mag;
                acc_q    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                a_q      <= bus.a;
                is_div_q <= op_div;
                div0_q   <= (bus.b == '0);
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
`ifdef MDU_MADD_EN
                accum_q     <= op_accum;
                accum_sub_q <= op_accum_sub;
`endif
              end else if (bus.op == OpMthi) begin
                hi_q <= bus.a;
              end else if (bus.op == OpMtlo) begin
                lo_q <= bus.a;
              end
            end
          end
          StCalc: begin
            acc_q <= is_div_q ? acc_div_d : acc_mul_d;
            if (cnt_q == '0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StFix: begin
            {hi_q, lo_q} <= hilo_fix_d;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative (WIDTH=32): reset, MTHI/MTLO, MULT/DIV corner cases,
// latency, flush, reset abort and the optional multiply-accumulate ops.
module tb_mdu_iterative;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  mdu_iterative_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish (obs=running exp=finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat;
    bit busy_ok;
    issue(op, a, b);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
    chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  // Idle for n cycles and report whether done or busy ever rose.
  task automatic idle_watch(input int n, output bit saw_done, output bit saw_busy);
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
    end
  endtask

  initial begin
    bit sd;
    bit sb;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    // Reset
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // MTLO / MTHI are single cycle and never raise busy
    issue(4'd6, 32'h1234_5678, 32'h0);
    chk("mtlo_lo", 64'(bus.lo), 64'h1234_5678);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    issue(4'd5, 32'hCAFE_F00D, 32'h0);
    chk("mthi_hi", 64'(bus.hi), 64'hCAFE_F00D);
    idle_watch(3, sd, sb);
    chk("mtx_no_busy", 64'(sb), 64'd0);
    chk("mtx_no_done", 64'(sd), 64'd0);

    // Multiply
    run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_negneg", 4'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'h0, 32'd10);

    // Divide
    run_op("divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_negpos", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_posneg", 4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_zero", 4'd4, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 4'd3, 32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Unassigned op codes behave as NOP
    issue(4'd7, 32'h1, 32'h1);
    issue(4'd12, 32'h1, 32'h1);
    idle_watch(3, sd, sb);
    chk("nop_no_busy", 64'(sb), 64'd0);
    chk("nop_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFF7_FFFF_FFFF);

    // Flush mid-op; start while busy is ignored; flush with start drops the start
    issue(4'd5, 32'hAAAA_5555, 32'h0);
    issue(4'd6, 32'h0F0F_0F0F, 32'h0);
    issue(4'd2, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    issue(4'd6, 32'hDEAD_BEEF, 32'h0);
    chk("busy_start_ignored_lo", 64'(bus.lo), 64'h0F0F_0F0F);
    chk("busy_still", 64'(bus.busy), 64'd1);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    issue(4'd5, 32'h1111_1111, 32'h0);
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    idle_watch(40, sd, sb);
    chk("flush_no_done", 64'(sd), 64'd0);
    chk("flush_no_busy", 64'(sb), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'hAAAA_5555_0F0F_0F0F);
    run_op("after_flush", 4'd2, 32'd5, 32'd6, 32'h0, 32'd30);

    // Flush in IDLE suppresses MTHI
    bus.flush = 1'b1;
    issue(4'd5, 32'h2222_2222, 32'h0);
    bus.flush = 1'b0;
    chk("flush_mthi", 64'(bus.hi), 64'h0);

    // Reset mid-op aborts without done
    issue(4'd1, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    idle_watch(40, sd, sb);
    chk("rst_mid_no_done", 64'(sd), 64'd0);

    // Multiply-accumulate
    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'd10, 32'h0);
`ifdef MDU_MADD_EN
    run_op("madd", 4'd8, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'd4);
    run_op("msubu", 4'd11, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue(4'd8, 32'hFFFF_FFFE, 32'd3);
    chk("madd_off_busy", 64'(bus.busy), 64'd0);
    issue(4'd11, 32'd1, 32'd5);
    chk("msubu_off_busy", 64'(bus.busy), 64'd0);
    idle_watch(40, sd, sb);
    chk("madd_off_no_done", 64'(sd), 64'd0);
    chk("madd_off_no_busy", 64'(sb), 64'd0);
    chk("madd_off_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
